// File: rtl/seg7_refresh_ctrl.sv
// Two-digit 7-segment refresh controller sharing one registered decoder between tens and ones.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module seg7_refresh_ctrl #(
  parameter int DEC_LAT   = 1,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Load,
  input  logic [7:0] i_Value,
  input  logic       i_Blink,
  output logic [3:0] o_Dec_Num,
  input  logic [6:0] i_Dec_Seg,
  output logic [6:0] o_Seg1,
  output logic [6:0] o_Seg2,
  output logic       o_Busy,
  output logic       o_Update
);

  localparam int WW = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(DEC_LAT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_T = 3'd1,
    CAP_T   = 3'd2,
    ISSUE_O = 3'd3,
    CAP_O   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [WW-1:0]   wait_r, wait_s;
  logic [7:0]      pend_r, pend_s;
  logic            pend_vld_r, pend_vld_s;
  logic [7:0]      active_r, active_s;
  logic [3:0]      dec_num_r, dec_num_s;
  logic [6:0]      seg1_hold_r, seg1_hold_s;
  logic [6:0]      seg2_hold_r, seg2_hold_s;
  logic [6:0]      seg1_r, seg2_r;
  logic            update_r, update_s;
  logic            busy_r;
  logic [BW-1:0]   blink_cnt_r, blink_cnt_s;
  logic            blink_on_r, blink_on_s;
  logic            start_s;

  // FSM state and decoder-latency wait counter
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= IDLE;
      wait_r  <= '0;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
    end
  end

  assign start_s = (state_r == IDLE) && (pend_vld_r || i_Load);

  // Next-state logic: each ISSUE state waits DEC_LAT cycles in total before capture
  always_comb begin
    state_s = state_r;
    wait_s  = wait_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = ISSUE_T;
          wait_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE_T: begin
        if (wait_r == WAIT_LAST) begin
          state_s = CAP_T;
          wait_s  = '0;
        end else begin
          wait_s = wait_r + WW'(1);
        end
      end
      CAP_T: state_s = ISSUE_O;
      ISSUE_O: begin
        if (wait_r == WAIT_LAST) begin
          state_s = CAP_O;
          wait_s  = '0;
        end else begin
          wait_s = wait_r + WW'(1);
        end
      end
      CAP_O: state_s = IDLE;
      default: begin
        state_s = IDLE;
        wait_s  = '0;
      end
    endcase
  end

  // Output/datapath next values: pending buffer, decoder nibble, digit capture
  always_comb begin
    pend_s      = pend_r;
    pend_vld_s  = pend_vld_r;
    active_s    = active_r;
    dec_num_s   = dec_num_r;
    seg1_hold_s = seg1_hold_r;
    seg2_hold_s = seg2_hold_r;
    update_s    = 1'b0;
    if (start_s) begin
      // a simultaneous load bypasses the pending buffer
      active_s   = i_Load ? i_Value : pend_r;
      pend_vld_s = 1'b0;
      dec_num_s  = active_s[7:4];
    end else if (i_Load) begin
      pend_s     = i_Value;
      pend_vld_s = 1'b1;
    end else begin
      pend_vld_s = pend_vld_r;
    end
    case (state_r)
      CAP_T: begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        seg1_hold_s = (active_r[7:4] == 4'd0) ? 7'd0 : i_Dec_Seg;
`else
        seg1_hold_s = i_Dec_Seg;
`endif
        dec_num_s = active_r[3:0];
      end
      CAP_O: begin
        seg2_hold_s = i_Dec_Seg;
        update_s    = 1'b1;
      end
      default: begin
        update_s = 1'b0;
      end
    endcase
  end

  // Blink divider: phase flips each time the counter wraps while blinking
  always_comb begin
    blink_cnt_s = blink_cnt_r;
    blink_on_s  = blink_on_r;
    if (!i_Blink) begin
      blink_cnt_s = '0;
      blink_on_s  = 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_s = '0;
      blink_on_s  = ~blink_on_r;
    end else begin
      blink_cnt_s = blink_cnt_r + BW'(1);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pend_r      <= 8'd0;
      pend_vld_r  <= 1'b0;
      active_r    <= 8'd0;
      dec_num_r   <= 4'd0;
      seg1_hold_r <= 7'd0;
      seg2_hold_r <= 7'd0;
      seg1_r      <= 7'd0;
      seg2_r      <= 7'd0;
      update_r    <= 1'b0;
      busy_r      <= 1'b0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      pend_r      <= pend_s;
      pend_vld_r  <= pend_vld_s;
      active_r    <= active_s;
      dec_num_r   <= dec_num_s;
      seg1_hold_r <= seg1_hold_s;
      seg2_hold_r <= seg2_hold_s;
      seg1_r      <= blink_on_s ? seg1_hold_s : 7'd0;
      seg2_r      <= blink_on_s ? seg2_hold_s : 7'd0;
      update_r    <= update_s;
      busy_r      <= (state_s != IDLE) || pend_vld_s;
      blink_cnt_r <= blink_cnt_s;
      blink_on_r  <= blink_on_s;
    end
  end

  assign o_Dec_Num = dec_num_r;
  assign o_Seg1    = seg1_r;
  assign o_Seg2    = seg2_r;
  assign o_Busy    = busy_r;
  assign o_Update  = update_r;

endmodule

// File: tb/tb_seg7_refresh_ctrl.sv
// Scoreboard bench for seg7_refresh_ctrl: random and directed loads against a round-level reference model.
module tb_seg7_refresh_ctrl;
  localparam int DEC_LAT   = 1;
  localparam int BLINK_DIV = 4;
  localparam int R         = 2 * (DEC_LAT + 1);

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Load = 1'b0;
  logic [7:0] i_Value = 8'd0;
  logic       i_Blink = 1'b0;
  logic [3:0] o_Dec_Num;
  logic [6:0] i_Dec_Seg;
  logic [6:0] o_Seg1, o_Seg2;
  logic       o_Busy, o_Update;

  seg7_refresh_ctrl #(.DEC_LAT(DEC_LAT), .BLINK_DIV(BLINK_DIV)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Load(i_Load), .i_Value(i_Value),
    .i_Blink(i_Blink), .o_Dec_Num(o_Dec_Num), .i_Dec_Seg(i_Dec_Seg),
    .o_Seg1(o_Seg1), .o_Seg2(o_Seg2), .o_Busy(o_Busy), .o_Update(o_Update)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [6:0] lut(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1110011;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] exp_tens(input logic [3:0] n);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (n == 4'd0) return 7'd0;
`endif
    return lut(n);
  endfunction

  // Board decoder: registered lookup with DEC_LAT cycles of latency
  logic [6:0] dec_pipe [DEC_LAT];
  always @(posedge i_Clk) begin
    dec_pipe[0] <= lut(o_Dec_Num);
    for (int i = 1; i < DEC_LAT; i++) dec_pipe[i] <= dec_pipe[i-1];
  end
  assign i_Dec_Seg = dec_pipe[DEC_LAT-1];

  int edge_cnt = 0;
  always @(posedge i_Clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [7:0] val;
    int         start;
    int         done;
  } round_t;

  round_t     q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         next_free = 0;
  bit         m_pend_vld = 1'b0;
  logic [7:0] m_pend = 8'd0;
  bit         exp_busy = 1'b0;
  int         exp_busy_edge = -1;
  bit         in_reset = 1'b1;
  logic [6:0] disp1 = 7'd0, disp2 = 7'd0;
  int         bk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // Apply one cycle of stimulus and advance the reference model to the coming edge
  task automatic drive_cycle(input bit ld, input logic [7:0] v, input bit bl);
    int e;
    round_t r;
    e = edge_cnt + 1;
    i_Load = ld;
    i_Value = v;
    i_Blink = bl;
    if (e >= next_free && (ld || m_pend_vld)) begin
      r.val = ld ? v : m_pend;
      r.start = e;
      r.done = e + R;
      q.push_back(r);
      m_pend_vld = 1'b0;
      next_free = e + R + 1;
    end else if (ld) begin
      m_pend = v;
      m_pend_vld = 1'b1;
    end
    bk = bl ? bk + 1 : 0;
    exp_busy = (e < next_free - 1) || m_pend_vld;
    exp_busy_edge = e;
    @(posedge i_Clk);
    #1;
  endtask

  // Monitor: pops the expected round whenever the DUT presents o_Update
  always @(negedge i_Clk) begin
    if (!in_reset) begin
      if (q.size() > 0) begin
        if (edge_cnt == q[0].start)
          check("dec_tens", 32'(o_Dec_Num), 32'(q[0].val[7:4]));
        if (edge_cnt == q[0].start + DEC_LAT + 1) begin
          check("dec_ones", 32'(o_Dec_Num), 32'(q[0].val[3:0]));
          check("seg1_cap", 32'(o_Seg1), 32'(exp_tens(q[0].val[7:4])));
        end
      end
      if (o_Update) begin
        if (q.size() == 0) begin
          check("update_unexpected", 32'(o_Update), 32'd0);
        end else begin
          check("update_edge", edge_cnt, q[0].done);
          check("seg1", 32'(o_Seg1), 32'(exp_tens(q[0].val[7:4])));
          check("seg2", 32'(o_Seg2), 32'(lut(q[0].val[3:0])));
          disp1 = exp_tens(q[0].val[7:4]);
          disp2 = lut(q[0].val[3:0]);
          q.delete(0);
        end
      end else if (q.size() > 0 && edge_cnt >= q[0].done) begin
        check("update_missing", 32'(o_Update), 32'd1);
        q.delete(0);
      end
      if (edge_cnt == exp_busy_edge)
        check("busy", 32'(o_Busy), 32'(exp_busy));
    end
  end

  initial begin
    bit on;
    #2;
    check("rst_seg1", 32'(o_Seg1), 32'd0);
    check("rst_seg2", 32'(o_Seg2), 32'd0);
    check("rst_dec", 32'(o_Dec_Num), 32'd0);
    check("rst_upd", 32'(o_Update), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    @(posedge i_Clk);
    @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    in_reset = 1'b0;

    // directed rounds
    drive_cycle(1'b1, 8'h37, 1'b0);
    repeat (6) drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h05, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h12, 1'b0);
    drive_cycle(1'b1, 8'h48, 1'b0);
    repeat (12) drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h09, 1'b0);
    repeat (6) drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'hAF, 1'b0);
    repeat (6) drive_cycle(1'b0, 8'h00, 1'b0);

    // random loads, including back-to-back and overwritten pending values
    for (int i = 0; i < 300; i++)
      drive_cycle(($urandom_range(0, 2) == 0), 8'($urandom), 1'b0);
    repeat (20) drive_cycle(1'b0, 8'h00, 1'b0);

    // reset in the cycle after CAP_T with a load pending
    drive_cycle(1'b1, 8'h55, 1'b0);
    drive_cycle(1'b1, 8'h66, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    in_reset = 1'b1;
    i_Rst_L = 1'b0;
    #1;
    check("mid_rst_seg1", 32'(o_Seg1), 32'd0);
    check("mid_rst_seg2", 32'(o_Seg2), 32'd0);
    check("mid_rst_dec", 32'(o_Dec_Num), 32'd0);
    check("mid_rst_upd", 32'(o_Update), 32'd0);
    check("mid_rst_busy", 32'(o_Busy), 32'd0);
    q.delete();
    m_pend_vld = 1'b0;
    next_free = 0;
    bk = 0;
    disp1 = 7'd0;
    disp2 = 7'd0;
    @(posedge i_Clk);
    @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    in_reset = 1'b0;
    repeat (20) drive_cycle(1'b0, 8'h00, 1'b0);

    // blink
    drive_cycle(1'b1, 8'h88, 1'b0);
    repeat (8) drive_cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1);
      on = ((bk / BLINK_DIV) % 2) == 0;
      check("blink_seg1", 32'(o_Seg1), on ? 32'(disp1) : 32'd0);
      check("blink_seg2", 32'(o_Seg2), on ? 32'(disp2) : 32'd0);
    end
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("unblink_seg1", 32'(o_Seg1), 32'(disp1));
    check("unblink_seg2", 32'(o_Seg2), 32'(disp2));
    repeat (4) drive_cycle(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
